// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: STAGES-deep valid/ready register pipeline with bubble collapsing.
// Latency: STAGES cycles from input transfer to out_valid when not stalled; 1 word/cycle.
// Backpressure: combinational ready chain; a stage is ready when it is empty or its
// successor is ready. Optional occupancy counter under `PIPE_REG_CHAIN_OCC_EN.
module pipe_reg_chain #(
  parameter int              WIDTH      = 8,
  parameter int              STAGES     = 3,
  parameter logic [WIDTH-1:0] INIT_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [$clog2(STAGES+1)-1:0] occupancy
`endif
);

  // Per-stage valid bits and data registers; the last stage feeds the outputs.
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];

  // rdy[k]: stage k can take a word this cycle; rdy[STAGES] is the downstream ready.
  logic [STAGES:0]   rdy;
  // mv[k]: the word in stage k leaves it this cycle (to k+1 or out of the block).
  logic [STAGES-1:0] mv;
  // fill[k]: stage k receives a new word at the next edge.
  logic [STAGES-1:0] fill;
  logic              take;
  logic              out_fire;

  // Ready chain walks from the output back to the input so bubbles collapse.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v[k] | rdy[k+1];
    end
  end

  assign in_ready  = rdy[0] & !flush & !rst;
  assign take      = in_valid & in_ready;
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  assign out_fire  = v[STAGES-1] & out_ready;

  // Movement and refill conditions for every stage.
  always_comb begin
    mv   = '0;
    fill = '0;
    for (int k = 0; k < STAGES; k++) begin
      mv[k] = v[k] & rdy[k+1];
    end
    fill[0] = take;
    for (int k = 1; k < STAGES; k++) begin
      fill[k] = mv[k-1];
    end
  end

  // Valid bits: refill wins over a departing word; reset beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (fill[k]) begin
          v[k] <= 1'b1;
        end else if (mv[k]) begin
          v[k] <= 1'b0;
        end
      end
    end
  end

  // Data registers load only when their stage is refilled; otherwise they hold.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= INIT_VALUE;
      end
    end else begin
      if (fill[0]) begin
        d[0] <= in_data;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (fill[k]) begin
          d[k] <= d[k-1];
        end
      end
    end
  end

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int OCC_W = $clog2(STAGES + 1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  // Occupancy tracks accepted-minus-delivered words; simultaneous in/out cancels.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
    end else if (take && !out_fire) begin
      occupancy <= occupancy + OCC_ONE;
    end else if (!take && out_fire) begin
      occupancy <= occupancy - OCC_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Testbench for pipe_reg_chain: directed scenarios plus a randomized run checked
// against a word-list model (each held word carries its stage position).
// Occupancy checks are active only when `PIPE_REG_CHAIN_OCC_EN is defined.
module tb_pipe_reg_chain;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
`ifdef PIPE_REG_CHAIN_OCC_EN
  logic [1:0] occupancy;
`endif

  int total = 0;
  int bad = 0;

  // Model: words in acceptance order, each with its current stage position.
  logic [7:0] mq[$];
  int         mp[$];
  int         np[$];
  bit         m_pop;

  pipe_reg_chain #(.WIDTH(8), .STAGES(S), .INIT_VALUE(8'h00)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    .occupancy(occupancy)
`endif
  );

  always #5 clk = ~clk;

  // Each word moves one stage forward if the slot ahead is free after older words move.
  function automatic void m_move(input bit orr);
    int start;
    int lim;
    np.delete();
    m_pop = 1'b0;
    start = 0;
    if (mp.size() > 0 && mp[0] == S - 1 && orr) begin
      m_pop = 1'b1;
      start = 1;
    end
    for (int i = start; i < mp.size(); i++) begin
      lim = (np.size() == 0) ? S - 1 : np[np.size()-1] - 1;
      np.push_back((mp[i] + 1 <= lim) ? mp[i] + 1 : mp[i]);
    end
  endfunction

  function automatic bit m_in_ready(input bit orr, input bit fl, input bit rr);
    m_move(orr);
    return !fl && !rr && (np.size() == 0 || np[np.size()-1] > 0);
  endfunction

  function automatic bit m_out_valid();
    return mp.size() > 0 && mp[0] == S - 1;
  endfunction

  task automatic drive(input bit iv, input logic [7:0] dat, input bit orr,
                       input bit fl, input bit rr);
    @(negedge clk);
    in_valid  = iv;
    in_data   = dat;
    out_ready = orr;
    flush     = fl;
    rst       = rr;
    #1;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic tick();
    bit         ird;
    bit         ivv;
    bit         fl;
    bit         rr;
    logic [7:0] idd;
    ivv = in_valid;
    idd = in_data;
    fl  = flush;
    rr  = rst;
    ird = m_in_ready(out_ready, fl, rr);
    @(posedge clk);
    if (rr || fl) begin
      mq.delete();
      mp.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      mp = np;
      if (ivv && ird) begin
        mq.push_back(idd);
        mp.push_back(0);
      end
    end
  endtask

  task automatic test_reset();
    drive(0, 8'h00, 0, 0, 1);
    tick();
    drive(0, 8'h00, 0, 0, 1);
    tick();
    drive(0, 8'h00, 1, 0, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef PIPE_REG_CHAIN_OCC_EN
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
`endif
    tick();
  endtask

  task automatic test_stream();
    logic [7:0] w [3];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    for (int i = 0; i < 7; i++) begin
      drive(i < 3, (i < 3) ? w[i] : 8'h00, 1, 0, 0);
      if (i < 3) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, in_ready); end
      end
      total++; if (out_valid !== (i >= 3 && i <= 5)) begin bad++; $display("FAIL stream_out_valid i=%0d got=%b exp=%b", i, out_valid, (i >= 3 && i <= 5)); end
      if (i >= 3 && i <= 5) begin
        total++; if (out_data !== w[i-3]) begin bad++; $display("FAIL stream_out_data i=%0d got=%h exp=%h", i, out_data, w[i-3]); end
      end
      tick();
    end
  endtask

  task automatic test_fill_stall();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'hA2; exp_seq[1] = 8'hA3; exp_seq[2] = 8'hB4; exp_seq[3] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'hA1 + 8'(i), 0, 0, 0);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_in_ready i=%0d got=%b exp=1", i, in_ready); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'hEE, 0, 0, 0);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready i=%0d got=%b exp=0", i, in_ready); end
      total++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin bad++; $display("FAIL full_hold i=%0d got=%b/%h exp=1/a1", i, out_valid, out_data); end
`ifdef PIPE_REG_CHAIN_OCC_EN
      total++; if (occupancy !== 2'd3) begin bad++; $display("FAIL full_occupancy got=%0d exp=3", occupancy); end
`endif
      tick();
    end
    // Full with downstream ready: accept and emit on the same edge.
    drive(1, 8'hB4, 1, 0, 0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL both_in_ready got=%b exp=1", in_ready); end
    total++; if (out_data !== 8'hA1) begin bad++; $display("FAIL both_out_data got=%h exp=a1", out_data); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 1, 0, 0);
`ifdef PIPE_REG_CHAIN_OCC_EN
      if (i == 0) begin
        total++; if (occupancy !== 2'd3) begin bad++; $display("FAIL both_occupancy got=%0d exp=3", occupancy); end
      end
`endif
      total++; if (out_valid !== (i < 3)) begin bad++; $display("FAIL drain_valid i=%0d got=%b exp=%b", i, out_valid, (i < 3)); end
      if (i < 3) begin
        total++; if (out_data !== exp_seq[i]) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, out_data, exp_seq[i]); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    drive(1, 8'hD1, 0, 0, 0); tick();
    drive(1, 8'hD2, 0, 0, 0); tick();
    drive(1, 8'hC5, 0, 1, 0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 8'h00, 1, 0, 0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid i=%0d got=%b exp=0", i, out_valid); end
      if (i == 0) begin
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL flush_out_data got=%h exp=00", out_data); end
`ifdef PIPE_REG_CHAIN_OCC_EN
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occupancy got=%0d exp=0", occupancy); end
`endif
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    drive(1, 8'hE1, 0, 0, 0); tick();
    drive(1, 8'hE2, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 0, 1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 8'h00, 1, 0, 0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid i=%0d got=%b exp=0", i, out_valid); end
      if (i == 0) begin
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_mid_out_data got=%h exp=00", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
`ifdef PIPE_REG_CHAIN_OCC_EN
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_mid_occupancy got=%0d exp=0", occupancy); end
`endif
      end
      tick();
    end
  endtask

  task automatic test_random();
    int  accepted;
    int  cycles;
    bit  iv;
    bit  orr;
    bit  fl;
    bit  exp_rdy;
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 20000) begin
      iv  = ($urandom_range(0, 9) < 7);
      orr = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 199) == 0);
      drive(iv, 8'($urandom), orr, fl, 0);
      exp_rdy = m_in_ready(orr, fl, 1'b0);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cycles, in_ready, exp_rdy); end
      total++; if (out_valid !== m_out_valid()) begin bad++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cycles, out_valid, m_out_valid()); end
      if (m_out_valid()) begin
        total++; if (out_data !== mq[0]) begin bad++; $display("FAIL rand_out_data cyc=%0d got=%h exp=%h", cycles, out_data, mq[0]); end
      end
`ifdef PIPE_REG_CHAIN_OCC_EN
      total++; if (occupancy !== 2'(mq.size())) begin bad++; $display("FAIL rand_occupancy cyc=%0d got=%0d exp=%0d", cycles, occupancy, mq.size()); end
`endif
      if (iv && exp_rdy) accepted++;
      tick();
      cycles++;
    end
    total++; if (accepted < 1000) begin bad++; $display("FAIL rand_timeout got=%0d exp=1000", accepted); end
    // Drain: every remaining word must come out in order, then the chain is empty.
    for (int i = 0; i < S + 2; i++) begin
      drive(0, 8'h00, 1, 0, 0);
      total++; if (out_valid !== m_out_valid()) begin bad++; $display("FAIL drain_rand_valid i=%0d got=%b exp=%b", i, out_valid, m_out_valid()); end
      if (m_out_valid()) begin
        total++; if (out_data !== mq[0]) begin bad++; $display("FAIL drain_rand_data i=%0d got=%h exp=%h", i, out_data, mq[0]); end
      end
      tick();
    end
    total++; if (mq.size() != 0 || out_valid !== 1'b0) begin bad++; $display("FAIL drain_rand_empty got=%0d/%b exp=0/0", mq.size(), out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_stall();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
